// File: rtl/relay_pulse_sequencer_pkg.sv
// Shared types and defaults for the K1/K2 relay pulse sequencer.
package relay_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        K1_ON,
        DEAD1,
        K2_ON,
        GAP,
        DONE
    } seq_state_e;

    localparam int DEF_CNT_W     = 32;
    localparam int DEF_K1_WIDTH  = 4000;
    localparam int DEF_DEAD_TIME = 1000;
    localparam int DEF_K2_WIDTH  = 4000;
    localparam int DEF_REP_W     = 8;

    // A repeat request of zero still fires one K1/K2 pass.
    function automatic int unsigned rep_at_least_one(input int unsigned reps);
        return (reps == 0) ? 1 : reps;
    endfunction

endpackage

// File: rtl/relay_pulse_sequencer_if.sv
// Control/status bundle between the board trigger logic and the relay sequencer.
interface relay_pulse_sequencer_if
    import relay_seq_pkg::*;
#(
    parameter int REP_W = DEF_REP_W
);
    logic             enable;
    logic             TEM;
    logic [REP_W-1:0] repeat_cnt;
    logic             K1;
    logic             K2;
    logic             busy;
    logic             done;
    logic             missed_trig;

    modport master (
        output enable, TEM, repeat_cnt,
        input  K1, K2, busy, done, missed_trig
    );

    modport slave (
        input  enable, TEM, repeat_cnt,
        output K1, K2, busy, done, missed_trig
    );
endinterface

// File: rtl/relay_pulse_sequencer_tem_edge_sync.sv
// Two-flop synchronizer plus history flop; emits a one-cycle pulse on each rising edge.
module tem_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);
    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
endmodule

// File: rtl/relay_pulse_sequencer.sv
// Sequences K1 pulse, dead time, K2 pulse (repeated) from one TEM edge; K1 and K2 never overlap.
module relay_pulse_sequencer
    import relay_seq_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int K1_WIDTH  = DEF_K1_WIDTH,
    parameter int DEAD_TIME = DEF_DEAD_TIME,
    parameter int K2_WIDTH  = DEF_K2_WIDTH,
    parameter int REP_W     = DEF_REP_W
)(
    input  logic                    clk,
    input  logic                    rst_n,
    relay_pulse_sequencer_if.slave  bus
);
    localparam logic [CNT_W-1:0] K1_LAST   = CNT_W'(K1_WIDTH - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME - 1);
    localparam logic [CNT_W-1:0] K2_LAST   = CNT_W'(K2_WIDTH - 1);

    if (DEAD_TIME < 1) begin : g_dead_chk
        $error("relay_pulse_sequencer: DEAD_TIME must be >= 1");
    end
    if (K1_WIDTH < 1 || K2_WIDTH < 1 ||
        longint'(K1_WIDTH) > (longint'(1) << CNT_W) ||
        longint'(K2_WIDTH) > (longint'(1) << CNT_W)) begin : g_width_chk
        $error("relay_pulse_sequencer: K1_WIDTH/K2_WIDTH out of range");
    end

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] passes_q, passes_d;
    logic             trig;

    tem_edge_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.TEM),
        .rise_o  (trig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            passes_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            passes_q <= passes_d;
        end
    end

    // Dropping enable aborts any running sequence before the phase logic is considered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        passes_d = passes_q;
        if (state_q != IDLE && !bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig && bus.enable) begin
                        passes_d = REP_W'(rep_at_least_one(32'(bus.repeat_cnt)));
                        cnt_d    = '0;
                        state_d  = K1_ON;
                    end
                end
                K1_ON: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == K1_LAST) begin
                        cnt_d   = '0;
                        state_d = DEAD1;
                    end
                end
                DEAD1: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == DEAD_LAST) begin
                        cnt_d   = '0;
                        state_d = K2_ON;
                    end
                end
                K2_ON: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == K2_LAST) begin
                        cnt_d = '0;
                        if (passes_q > REP_W'(1)) begin
                            passes_d = passes_q - REP_W'(1);
                            state_d  = GAP;
                        end else begin
                            state_d  = DONE;
                        end
                    end
                end
                GAP: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == DEAD_LAST) begin
                        cnt_d   = '0;
                        state_d = K1_ON;
                    end
                end
                DONE: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.K1          = (state_q == K1_ON);
    assign bus.K2          = (state_q == K2_ON);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.missed_trig = trig && (state_q != IDLE);
endmodule

// File: tb/tb_relay_pulse_sequencer.sv
// Self-checking bench: each scenario compares per-cycle outputs with a timeline built from the pulse rules.
module tb_relay_pulse_sequencer;
    localparam int K1W = 4;
    localparam int DT  = 2;
    localparam int K2W = 3;
    localparam int RW  = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // Expected {K1,K2,busy,done} per sampled cycle, starting the cycle after TEM rises.
    logic [3:0] expQ[$];
    logic [3:0] obs;
    logic       obsMissed;
    logic [3:0] expv;

    relay_pulse_sequencer_if #(.REP_W(RW)) bus ();

    relay_pulse_sequencer #(
        .CNT_W     (32),
        .K1_WIDTH  (K1W),
        .DEAD_TIME (DT),
        .K2_WIDTH  (K2W),
        .REP_W     (RW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // K1 and K2 must never be driven together.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (bus.K1 === 1'b1 && bus.K2 === 1'b1) begin
                failures++;
                $display("[TB] FAIL k1_k2_overlap K1=%b K2=%b required not both 1", bus.K1, bus.K2);
            end
        end
    end

    // Timeline: two sync cycles, then per pass K1W high / DT dead / K2W high / DT gap (not after last), then done.
    function automatic void build_expected(input int reps);
        int passes;
        passes = (reps == 0) ? 1 : reps;
        expQ.delete();
        repeat (2) expQ.push_back(4'b0000);
        for (int p = 0; p < passes; p++) begin
            repeat (K1W) expQ.push_back(4'b1010);
            repeat (DT)  expQ.push_back(4'b0010);
            repeat (K2W) expQ.push_back(4'b0110);
            if (p < passes - 1) repeat (DT) expQ.push_back(4'b0010);
        end
        expQ.push_back(4'b0011);
    endfunction

    function automatic logic [3:0] exp_at(input int i);
        return (i < expQ.size()) ? expQ[i] : 4'b0000;
    endfunction

    task automatic step();
        @(negedge clk);
        obs       = {bus.K1, bus.K2, bus.busy, bus.done};
        obsMissed = bus.missed_trig;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.enable     = 1'b1;
        bus.TEM        = 1'b0;
        bus.repeat_cnt = 8'd1;
        repeat (3) step();
        checks++;
        if ({obs, obsMissed} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b required=%b", {obs, obsMissed}, 5'b0);
        end
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if ({obs, obsMissed} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_idle got=%b required=%b", {obs, obsMissed}, 5'b0);
        end
    endtask

    task automatic test_single_pass();
        bus.repeat_cnt = 8'd1;
        build_expected(1);
        bus.TEM = 1'b1;
        for (int i = 0; i < expQ.size() + 4; i++) begin
            step();
            expv = exp_at(i);
            checks++;
            if ({obs, obsMissed} !== {expv, 1'b0}) begin
                failures++;
                $display("[TB] FAIL single_pass cyc=%0d got=%b required=%b", i, {obs, obsMissed}, {expv, 1'b0});
            end
        end
        bus.TEM = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_repeat();
        for (int r = 0; r < 3; r++) begin
            int reps;
            reps = (r == 0) ? 3 : int'($urandom_range(2, 5));
            bus.repeat_cnt = RW'(reps);
            build_expected(reps);
            bus.TEM = 1'b1;
            for (int i = 0; i < expQ.size() + 4; i++) begin
                step();
                if (i == 3) bus.TEM = 1'b0;
                if (i == 5) bus.repeat_cnt = RW'($urandom_range(0, 255));
                expv = exp_at(i);
                checks++;
                if ({obs, obsMissed} !== {expv, 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL repeat reps=%0d cyc=%0d got=%b required=%b", reps, i, {obs, obsMissed}, {expv, 1'b0});
                end
            end
        end
    endtask

    task automatic test_missed();
        int k;
        bus.repeat_cnt = 8'd1;
        build_expected(1);
        k = 0;
        while (k < expQ.size() && expQ[k][2] !== 1'b1) k++;
        bus.TEM = 1'b1;
        for (int i = 0; i < expQ.size() + 8; i++) begin
            step();
            if (i == 2) bus.TEM = 1'b0;
            if (i == k) bus.TEM = 1'b1;
            expv = exp_at(i);
            checks++;
            if ({obs, obsMissed} !== {expv, (i == k + 2)}) begin
                failures++;
                $display("[TB] FAIL missed_trig cyc=%0d got=%b required=%b", i, {obs, obsMissed}, {expv, (i == k + 2)});
            end
        end
        bus.TEM = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_enable_drop();
        for (int r = 0; r < 2; r++) begin
            int j;
            bus.repeat_cnt = RW'($urandom_range(1, 2));
            build_expected(int'(bus.repeat_cnt));
            j = (r == 0) ? 3 : int'($urandom_range(2, expQ.size() - 1));
            bus.TEM = 1'b1;
            for (int i = 0; i < expQ.size() + 4; i++) begin
                step();
                if (i == j) begin
                    bus.enable = 1'b0;
                    bus.TEM    = 1'b0;
                end
                expv = (i <= j) ? exp_at(i) : 4'b0000;
                checks++;
                if ({obs, obsMissed} !== {expv, 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL enable_drop j=%0d cyc=%0d got=%b required=%b", j, i, {obs, obsMissed}, {expv, 1'b0});
                end
            end
            bus.enable = 1'b1;
            repeat (2) step();
            test_single_pass();
        end
    endtask

    task automatic test_reset_mid();
        int k;
        bus.repeat_cnt = 8'd2;
        build_expected(2);
        k = 0;
        while (k < expQ.size() && expQ[k][2] !== 1'b1) k++;
        bus.TEM = 1'b1;
        for (int i = 0; i <= k; i++) begin
            step();
            expv = exp_at(i);
            checks++;
            if ({obs, obsMissed} !== {expv, 1'b0}) begin
                failures++;
                $display("[TB] FAIL pre_reset cyc=%0d got=%b required=%b", i, {obs, obsMissed}, {expv, 1'b0});
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.K1, bus.K2, bus.busy, bus.done, bus.missed_trig} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL async_reset got=%b required=%b",
                     {bus.K1, bus.K2, bus.busy, bus.done, bus.missed_trig}, 5'b0);
        end
        bus.TEM = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        checks++;
        if ({obs, obsMissed} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_idle got=%b required=%b", {obs, obsMissed}, 5'b0);
        end
        test_single_pass();
    endtask

    task automatic test_zero_held();
        bus.repeat_cnt = 8'd0;
        build_expected(0);
        bus.TEM = 1'b1;
        for (int i = 0; i < 53; i++) begin
            step();
            if (i == 49) bus.TEM = 1'b0;
            expv = exp_at(i);
            checks++;
            if ({obs, obsMissed} !== {expv, 1'b0}) begin
                failures++;
                $display("[TB] FAIL zero_held cyc=%0d got=%b required=%b", i, {obs, obsMissed}, {expv, 1'b0});
            end
        end
        bus.enable = 1'b0;
        bus.TEM    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({obs, obsMissed} !== 5'b0) begin
                failures++;
                $display("[TB] FAIL disabled_idle cyc=%0d got=%b required=%b", i, {obs, obsMissed}, 5'b0);
            end
        end
        bus.TEM = 1'b0;
        repeat (3) step();
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({obs, obsMissed} !== 5'b0) begin
                failures++;
                $display("[TB] FAIL reenable_idle cyc=%0d got=%b required=%b", i, {obs, obsMissed}, 5'b0);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int reps, hold, gap;
            reps = int'($urandom_range(0, 4));
            hold = int'($urandom_range(1, 20));
            bus.repeat_cnt = RW'(reps);
            build_expected(reps);
            gap = (hold + 3 > expQ.size()) ? hold + 3 - expQ.size() : 3;
            bus.TEM = 1'b1;
            for (int i = 0; i < expQ.size() + gap; i++) begin
                step();
                if (i == hold - 1) bus.TEM = 1'b0;
                if (i == 2) bus.repeat_cnt = RW'($urandom_range(0, 255));
                expv = exp_at(i);
                checks++;
                if ({obs, obsMissed} !== {expv, 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL random reps=%0d hold=%0d cyc=%0d got=%b required=%b",
                             reps, hold, i, {obs, obsMissed}, {expv, 1'b0});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_repeat();
        test_missed();
        test_enable_drop();
        test_reset_mid();
        test_zero_held();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/relay_pulse_sequencer.md
Name: relay_pulse_sequencer

Overview:
- Controller that sequences the board's two relay drive lines, K1 and K2, from one TEM trigger edge.
- Each run fires a K1 pulse, then a guaranteed dead time, then a K2 pulse; the K1/dead/K2 pass repeats a programmable number of times.
- K1 and K2 are never high together.
- Sits between the TEM input pin and the relay drivers on the test board, replacing free-running pulse logic with a busy/done-handshaked sequencer.

Parameters:
- CNT_W, 32: width of the phase cycle counter.
- K1_WIDTH, 4000: K1 high time in clk cycles; must be ≥1 and ≤ 2^CNT_W.
- DEAD_TIME, 1000: cycles with both outputs low between K1→K2 and between passes; must be ≥1 (elaboration-time check).
- K2_WIDTH, 4000: K2 high time in clk cycles; must be ≥1 and ≤ 2^CNT_W.
- REP_W, 8: width of the repeat count.

Ports:
- clk, input, 1: single system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: sequencer enable, level-sensitive, synchronous to clk.
- TEM, input, 1: trigger input, asynchronous to clk.
- repeat_cnt, input, REP_W: number of K1/K2 passes per trigger; 0 is treated as 1.
- K1, output, 1: relay 1 drive.
- K2, output, 1: relay 2 drive.
- busy, output, 1: sequence in progress.
- done, output, 1: 1-cycle pulse at normal completion.
- missed_trig, output, 1: 1-cycle pulse when a trigger edge is ignored.

Behaviour:
- Reset: rst_n low forces K1, K2, busy, done and missed_trig to 0 immediately, without waiting for clk. It also puts the FSM in IDLE and clears the counter, pass counter and sync flops. Reset mid-sequence aborts with no done.
- TEM path: 2-flop synchronizer (s1, s2) plus a history flop s3. trig = s2 & ~s3.
- Latency: E0 is the first clk edge sampling TEM=1. trig is true between E1 and E2; the FSM enters K1_ON at E2, so K1 is high from E2.
- Outputs are Moore-decoded from registered state:
  - K1 = (state==K1_ON)
  - K2 = (state==K2_ON)
  - busy = (state!=IDLE)
  - done = (state==DONE)
- States and transitions:
  - IDLE: on trig & enable, latch passes = max(repeat_cnt,1), clear cnt, go to K1_ON.
  - K1_ON: cnt increments; at cnt==K1_WIDTH-1, clear cnt and go to DEAD1. K1 is high exactly K1_WIDTH cycles.
  - DEAD1: at cnt==DEAD_TIME-1, go to K2_ON.
  - K2_ON: at cnt==K2_WIDTH-1, decrement passes; go to GAP if passes>1 after... (see next line).
  - K2_ON exit rule: if passes (before decrement) > 1, go to GAP; otherwise go to DONE.
  - GAP: at cnt==DEAD_TIME-1, go to K1_ON.
  - DONE: one cycle, done=1, then IDLE.
- Counter compare is full CNT_W width; cnt clears on every state change and never wraps.
- Trigger while busy (any non-IDLE state, including DONE): ignored, missed_trig=1 for that cycle, sequence unaffected.
- Trigger in IDLE with enable=0: ignored, no missed_trig.
- enable low in any non-IDLE state: next edge goes to IDLE. K1/K2/busy fall on that edge; no done.
- enable low and trig on the same cycle: enable wins.
- TEM held high: only one edge, so only one sequence.
- repeat_cnt is sampled only at start; later changes have no effect on the running sequence.

Decomposition:
- Package relay_seq_pkg holds:
  - the state enum (IDLE, K1_ON, DEAD1, K2_ON, GAP, DONE);
  - default width constants;
  - the repeat-zero-as-one helper function.
- One sub-module, tem_edge_sync: clk, rst_n, async in → rise pulse. It contains the 2-flop synchronizer and the edge detect, and is reused for other board inputs.

Test Plan (K1_WIDTH=4, DEAD_TIME=2, K2_WIDTH=3, REP_W=8):
1. enable=1, repeat_cnt=1, TEM 0→1 sampled at E0 → K1 high E2..E6 (4 cycles), both low 2 cycles, K2 high 3 cycles, done=1 for 1 cycle immediately after K2 falls, busy high E2 through the done cycle.
2. repeat_cnt=3, single TEM edge → three K1(4)/dead(2)/K2(3) passes with 2-cycle gaps, K1&K2 never both 1 (assertion), exactly one done pulse.
3. Second TEM edge arriving during K2_ON of a run → missed_trig pulses once, K1/K2 timing identical to scenario 1, no second sequence.
4. enable dropped at the 2nd K1 cycle → K1 low on the next edge, busy low, no done. After re-enable, a new TEM edge produces a full scenario-1 sequence.
5. rst_n asserted mid-K2_ON between clock edges → K2 and busy low with no clk edge. After release and a TEM edge, the sequence starts cleanly.
6. repeat_cnt=0 with TEM held high 50 cycles → exactly one pass, one done. TEM with enable=0 in IDLE → no outputs change, no missed_trig.
